// File: rtl/gps_mode_fsm.sv
// gps_mode_fsm: GPS receiver mode tracker (IDLE/ACQ/RUN/RUN_APPROX/HOLD) with fix debounce, holdover and fix-age counter
module gps_mode_fsm #(
  parameter int DEBOUNCE_P = 4,
  parameter int HOLD_P = 16,
  parameter int AGE_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             gps_active_i,
  input  logic             fix_i,
  input  logic             approx_i,
  output logic             idle_o,
  output logic             aq_o,
  output logic             run_o,
  output logic             run_approx_o,
  output logic             hold_o,
  output logic [2:0]       state_o,
  output logic             lost_o,
  output logic [AGE_W-1:0] fix_age_o
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] ACQ = 3'd1;
  localparam logic [2:0] RUN = 3'd2;
  localparam logic [2:0] RUN_APPROX = 3'd3;
  localparam logic [2:0] HOLD = 3'd4;
  localparam int DW = $clog2(DEBOUNCE_P > 2 ? DEBOUNCE_P : 2);
  localparam int HW = $clog2(HOLD_P > 2 ? HOLD_P : 2);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_P - 1);
  localparam logic [HW-1:0] HC_LAST = HW'(HOLD_P - 1);
  logic [2:0] state, nxt;
  logic [DW-1:0] db, db_nxt;
  logic [HW-1:0] hc, hc_nxt;
  logic lost_nxt;
  always_comb begin
    nxt = IDLE;
    db_nxt = '0;
    hc_nxt = '0;
    lost_nxt = 1'b0;
    if (gps_active_i)
      case (state)
        IDLE: nxt = ACQ;
        ACQ: begin
          nxt = fix_i ? (db == DB_LAST ? RUN : ACQ) : approx_i ? RUN_APPROX : ACQ;
          db_nxt = (fix_i && db != DB_LAST) ? db + 1'b1 : '0;
        end
        RUN: nxt = fix_i ? RUN : approx_i ? RUN_APPROX : HOLD;
        RUN_APPROX: nxt = fix_i ? RUN : approx_i ? RUN_APPROX : ACQ;
        HOLD: begin
          lost_nxt = !fix_i && !approx_i && hc == HC_LAST;
          nxt = fix_i ? RUN : approx_i ? RUN_APPROX : lost_nxt ? ACQ : HOLD;
          hc_nxt = nxt == HOLD ? hc + 1'b1 : '0;
        end
        default: nxt = IDLE;
      endcase
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= IDLE;
      db <= '0;
      hc <= '0;
      lost_o <= 1'b0;
      fix_age_o <= '0;
    end else begin
      state <= nxt;
      db <= db_nxt;
      hc <= hc_nxt;
      lost_o <= lost_nxt;
      fix_age_o <= fix_i ? '0 : (&fix_age_o ? fix_age_o : fix_age_o + 1'b1);
    end
  // idle_o covers any unused encoding so the one-hot set never goes empty
  assign aq_o = state == ACQ;
  assign run_o = state == RUN;
  assign run_approx_o = state == RUN_APPROX;
  assign hold_o = state == HOLD;
  assign idle_o = !(aq_o || run_o || run_approx_o || hold_o);
  assign state_o = state;
endmodule

// File: tb/tb_gps_mode_fsm.sv
// tb_gps_mode_fsm: directed and randomized checks of gps_mode_fsm against a behavioural mode model
module tb_gps_mode_fsm;
  localparam int D = 4, H = 16, AMAX = 15;
  logic clk = 1'b0, rst, gps, fix, approx;
  logic idle, aq, run, run_approx, hold, lost;
  logic [2:0] state;
  logic [3:0] age;
  int checks = 0, failures = 0;
  int ms, mdb, mhc, mage;
  bit mlost;

  gps_mode_fsm #(.DEBOUNCE_P(D), .HOLD_P(H), .AGE_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .gps_active_i(gps), .fix_i(fix), .approx_i(approx),
    .idle_o(idle), .aq_o(aq), .run_o(run), .run_approx_o(run_approx), .hold_o(hold),
    .state_o(state), .lost_o(lost), .fix_age_o(age)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("state_o", 32'(state), 32'(ms));
    chk("onehot", 32'($countones({idle, aq, run, run_approx, hold})), 1);
    chk("idle_o", 32'(idle), 32'(ms == 0));
    chk("aq_o", 32'(aq), 32'(ms == 1));
    chk("run_o", 32'(run), 32'(ms == 2));
    chk("run_approx_o", 32'(run_approx), 32'(ms == 3));
    chk("hold_o", 32'(hold), 32'(ms == 4));
    chk("lost_o", 32'(lost), 32'(mlost));
    chk("fix_age_o", 32'(age), 32'(mage));
  endtask

  task automatic model_reset();
    ms = 0; mdb = 0; mhc = 0; mage = 0; mlost = 0;
  endtask

  // Mode numbers follow the published state_o values: 0 idle, 1 acq, 2 run, 3 approx, 4 hold
  task automatic model_step();
    int ns;
    ns = ms;
    mlost = 0;
    if (!gps) begin
      ns = 0;
      mdb = 0;
    end else if (ms == 0) ns = 1;
    else if (ms == 1) begin
      if (fix) begin
        mdb++;
        if (mdb == D) begin ns = 2; mdb = 0; end
      end else begin
        mdb = 0;
        if (approx) ns = 3;
      end
    end else if (ms == 2) begin
      if (!fix) ns = approx ? 3 : 4;
      mhc = 0;
    end else if (ms == 3) ns = fix ? 2 : approx ? 3 : 1;
    else if (ms == 4) begin
      if (fix) ns = 2;
      else if (approx) ns = 3;
      else if (mhc == H - 1) begin ns = 1; mlost = 1; end
      else mhc++;
    end
    if (ns != 4 && ms != 2) mhc = 0;
    ms = ns;
    mage = fix ? 0 : (mage + 1 > AMAX ? AMAX : mage + 1);
  endtask

  task automatic cyc(input logic g, input logic f, input logic a);
    gps = g; fix = f; approx = a;
    @(posedge clk);
    model_step();
    #1 check_all();
  endtask

  task automatic do_async_reset();
    #2 rst = 1'b1;
    model_reset();
    #1 check_all();
    @(negedge clk) rst = 1'b0;
  endtask

  initial begin
    int pf, pa;
    rst = 1'b1; gps = 0; fix = 0; approx = 0;
    model_reset();
    #3 check_all();
    @(negedge clk) rst = 1'b0;
    cyc(1, 0, 0);
    repeat (3) cyc(1, 1, 0);
    cyc(1, 0, 0);
    repeat (4) cyc(1, 1, 0);
    cyc(1, 0, 1);
    cyc(1, 0, 0);
    repeat (4) cyc(1, 1, 0);
    repeat (18) cyc(1, 0, 0);
    repeat (4) cyc(1, 1, 0);
    repeat (10) cyc(1, 0, 0);
    cyc(1, 1, 0);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    repeat (4) cyc(1, 1, 1);
    repeat (3) cyc(1, 0, 0);
    cyc(0, 0, 0);
    repeat (20) cyc(0, 0, 0);
    cyc(0, 1, 0);
    cyc(1, 0, 0);
    repeat (4) cyc(1, 1, 0);
    repeat (5) cyc(1, 0, 0);
    do_async_reset();
    repeat (2) cyc(1, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      case ((i / 500) % 6)
        0: begin pf = 50; pa = 20; end
        1: begin pf = 10; pa = 10; end
        2: begin pf = 5; pa = 3; end
        3: begin pf = 30; pa = 40; end
        4: begin pf = 2; pa = 2; end
        default: begin pf = 60; pa = 10; end
      endcase
      cyc($urandom_range(0, 99) < 97, $urandom_range(0, 99) < pf, $urandom_range(0, 99) < pa);
      if ($urandom_range(0, 999) < 3) do_async_reset();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gps_mode_fsm.md
GPS_MODE_FSM -- requirements
Module: gps_mode_fsm

Interface
REQ-001: Parameter DEBOUNCE_P, default 4, number of consecutive cycles fix_i must be high in ACQ before entering RUN; legal range >= 1.
REQ-002: Parameter HOLD_P, default 16, holdover length in cycles after fix_i and approx_i are both lost in RUN; legal range >= 1.
REQ-003: Parameter AGE_W, default 16, width of the fix-age counter.
REQ-004: clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-005: rst_i  input  1  asynchronous, active-high reset.
REQ-006: gps_active_i  input  1  GPS receiver powered and streaming.
REQ-007: fix_i  input  1  receiver reports a valid 3D fix this cycle.
REQ-008: approx_i  input  1  receiver reports an approximate (2D/dead-reckoned) solution this cycle.
REQ-009: idle_o  output  1  state is IDLE.
REQ-010: aq_o  output  1  state is ACQ.
REQ-011: run_o  output  1  state is RUN.
REQ-012: run_approx_o  output  1  state is RUN_APPROX.
REQ-013: hold_o  output  1  state is HOLD.
REQ-014: state_o  output  3  encoded state: IDLE=0, ACQ=1, RUN=2, RUN_APPROX=3, HOLD=4.
REQ-015: lost_o  output  1  one-cycle pulse when HOLD expires to ACQ.
REQ-016: fix_age_o  output  AGE_W  cycles since fix_i was last sampled high, saturating.

Function
REQ-017: Moore machine; one-hot outputs and state_o decode the state register only; an input sampled at rising edge N is reflected on outputs immediately after edge N.
REQ-018: Exactly one of idle_o, aq_o, run_o, run_approx_o, hold_o is high at all times, including during reset.
REQ-019: gps_active_i low at any edge forces IDLE from every state, overriding all other transitions.
REQ-020: IDLE -> ACQ when gps_active_i=1.
REQ-021: ACQ: debounce counter increments each cycle fix_i=1, clears when fix_i=0 or on leaving ACQ; ACQ -> RUN at the edge where fix_i=1 and counter == DEBOUNCE_P-1 (DEBOUNCE_P=1 gives single-cycle entry).
REQ-022: ACQ -> RUN_APPROX when approx_i=1 and fix_i=0; this transition is not debounced and clears the debounce counter.
REQ-023: RUN: fix_i=1 stays; fix_i=0 and approx_i=1 -> RUN_APPROX; both low -> HOLD with hold counter loaded to 0.
REQ-024: RUN_APPROX: fix_i=1 -> RUN (no debounce); approx_i=1 stays; both low -> ACQ.
REQ-025: HOLD: hold counter increments each cycle; fix_i=1 -> RUN; else approx_i=1 -> RUN_APPROX; else at the edge where counter == HOLD_P-1 -> ACQ with lost_o high for exactly the following cycle.
REQ-026: fix_i has priority over approx_i whenever both are high, in every state.
REQ-027: Fix-age counter clears to 0 at any edge where fix_i=1, otherwise increments by 1, saturating at 2^AGE_W-1 (no wrap); it runs in every state including IDLE.
REQ-028: Counters sized ceil(log2(max(P,2))) bits; no arithmetic overflow is reachable for any legal parameter.
REQ-029: Unused state encodings return to IDLE at the next edge.

Reset
REQ-030: While rst_i is high: state IDLE (idle_o=1, all other state outputs 0, state_o=0), lost_o=0, fix_age_o=0, debounce and hold counters 0.
REQ-031: Reset asserting mid-operation (e.g. in HOLD or mid-debounce) takes effect asynchronously without waiting for a clock edge; no lost_o pulse is produced.
REQ-032: After rst_i deasserts, the first transition occurs at the first rising edge with rst_i low.

Verification
REQ-033: Defaults; reset, gps_active_i=1 one cycle -> aq_o=1, state_o=1; fix_i=1 for 3 cycles then 0 -> remains ACQ; fix_i=1 for 4 cycles -> run_o=1 after 4th edge.
REQ-034: In RUN, fix_i=0, approx_i=1 -> run_approx_o=1 next edge; approx_i=0 -> aq_o=1 next edge.
REQ-035: In RUN, fix_i=approx_i=0 for 16 cycles -> hold_o=1 for 16 cycles, then aq_o=1 with lost_o=1 for exactly 1 cycle; fix_i=1 on hold cycle 10 instead -> run_o=1, lost_o stays 0.
REQ-036: From RUN or HOLD, gps_active_i=0 -> idle_o=1 next edge; fix_i and approx_i both 1 in ACQ with counter 0 -> run_o=0, run_approx_o=0, debounce continues toward RUN.
REQ-037: AGE_W=4, fix_i held 0 for 20 cycles -> fix_age_o saturates at 15; single fix_i=1 -> 0.
REQ-038: Assert rst_i asynchronously between edges in HOLD -> idle_o=1, hold_o=0 before next edge; one-hot invariant checked every cycle.
